// File: rtl/rise_counter_bank.sv
// ---------------------------------------------------------------------------
// rise_counter_bank
//   NUM_CH independent event counters. Each channel counts rising edges of its
//   own sig input (EDGE_MODE=1) or every cycle sig is high (EDGE_MODE=0) while
//   enabled. A counter either wraps to zero or holds at its maximum on overflow
//   (SATURATE), and in both cases it raises a sticky per-channel overflow flag.
//   A global snapshot register captures all live counts at one instant, so
//   software can read every channel coherently.
//
// Ports
//   clk       in   system clock, all state on posedge
//   rst_n     in   synchronous reset, active HIGH (1 = reset)
//   enb       in   [NUM_CH]        per-channel enable; 0 holds channel at zero
//   sig       in   [NUM_CH]        per-channel event input, synchronous to clk
//   clr       in   [NUM_CH]        per-channel counter clear pulse
//   snap      in   capture all live counts into snap_cnt
//   ovf_clr   in   clear every sticky overflow flag
//   cnt       out  [NUM_CH*CNT_W]  live counts, channel i at [i*CNT_W +: CNT_W]
//   snap_cnt  out  [NUM_CH*CNT_W]  captured counts, same packing as cnt
//   snap_vld  out  one-cycle pulse, snap_cnt was just updated
//   ovf       out  [NUM_CH]        sticky overflow flags
// ---------------------------------------------------------------------------
module rise_counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 12,
  parameter bit SATURATE  = 1'b0,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enb,
  input  logic [NUM_CH-1:0]       sig,
  input  logic [NUM_CH-1:0]       clr,
  input  logic                    snap,
  input  logic                    ovf_clr,
  output logic [NUM_CH*CNT_W-1:0] cnt,
  output logic [NUM_CH*CNT_W-1:0] snap_cnt,
  output logic                    snap_vld,
  output logic [NUM_CH-1:0]       ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0]       sig_d_q,    sig_d_d;
  logic [NUM_CH*CNT_W-1:0] cnt_q,      cnt_d;
  logic [NUM_CH*CNT_W-1:0] snap_cnt_q, snap_cnt_d;
  logic                    snap_vld_q, snap_vld_d;
  logic [NUM_CH-1:0]       ovf_q,      ovf_d;
  logic [NUM_CH-1:0]       event_v;

  // sig_d tracks sig regardless of enb/clr, so a level that was already high
  // while the channel was disabled does not count as a fresh edge later.
  always_comb begin
    if (EDGE_MODE) event_v = sig & ~sig_d_q;
    else           event_v = sig;
  end

  always_comb begin
    sig_d_d    = sig;
    cnt_d      = cnt_q;
    // A new overflow below overrides the clear, so set wins on the same edge.
    ovf_d      = ovf_q & ~{NUM_CH{ovf_clr}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (!enb[i]) begin
        cnt_d[i*CNT_W +: CNT_W] = '0;
      end else if (clr[i]) begin
        cnt_d[i*CNT_W +: CNT_W] = '0;
      end else if (event_v[i]) begin
        if (cnt_q[i*CNT_W +: CNT_W] == CNT_MAX) begin
          cnt_d[i*CNT_W +: CNT_W] = SATURATE ? CNT_MAX : '0;
          ovf_d[i]                = 1'b1;
        end else begin
          cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
    // Snapshot takes the registered (pre-update) counts, which makes
    // snap together with clr a read-and-clear.
    snap_cnt_d = snap ? cnt_q : snap_cnt_q;
    snap_vld_d = snap;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sig_d_q    <= '0;
      cnt_q      <= '0;
      snap_cnt_q <= '0;
      snap_vld_q <= 1'b0;
      ovf_q      <= '0;
    end else begin
      sig_d_q    <= sig_d_d;
      cnt_q      <= cnt_d;
      snap_cnt_q <= snap_cnt_d;
      snap_vld_q <= snap_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign cnt      = cnt_q;
  assign snap_cnt = snap_cnt_q;
  assign snap_vld = snap_vld_q;
  assign ovf      = ovf_q;

endmodule
